fb_write_scheduler: RTL and testbench
=====================================

# fb_write_scheduler

Parametrised multi-source write scheduler for the VGA framebuffer. It accepts pixel writes (hpos, vpos, rgb) from N_SRC producers (ROM loader, brush, future sprite engine) through valid/ready handshakes with round-robin arbitration. Accepted writes are buffered in an internal FIFO and drained into the framebuffer write port only during blanking, when the memory clear is not running. It replaces the fixed single-producer FIFO path and the display/FIFO position mux of the current top level.

## Interface
Parameters:
- N_SRC, 2, number of write sources
- HPOS_WIDTH, 10, horizontal coordinate width
- VPOS_WIDTH, 10, vertical coordinate width
- RGB_WIDTH, 3, pixel width
- DEPTH, 16, FIFO entries; power of two, ≥2
- RESOLUTION_H, 640, valid hpos range 0..RESOLUTION_H-1
- RESOLUTION_V, 480, valid vpos range 0..RESOLUTION_V-1
- FULL_POLICY, 0, 0 = stall (backpressure), 1 = drop new write and count it
- CNT_WIDTH, 16, width of drop_cnt

Ports:
- clk  in  1  single clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- src_valid  in  N_SRC  per-source write request
- src_ready  out  N_SRC  per-source grant/accept
- src_hpos  in  N_SRC*HPOS_WIDTH  packed; source i at [i*HPOS_WIDTH +: HPOS_WIDTH]
- src_vpos  in  N_SRC*VPOS_WIDTH  packed, same scheme
- src_rgb  in  N_SRC*RGB_WIDTH  packed, same scheme
- display_on  in  1  raster in visible area
- mem_busy  in  1  framebuffer clear in progress
- hpos  in  HPOS_WIDTH  raster horizontal position
- vpos  in  VPOS_WIDTH  raster vertical position
- fb_hpos  out  HPOS_WIDTH  framebuffer address x
- fb_vpos  out  VPOS_WIDTH  framebuffer address y
- fb_rgb  out  RGB_WIDTH  write data
- fb_we  out  1  framebuffer write strobe
- level  out  $clog2(DEPTH+1)  FIFO occupancy
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- drop_cnt  out  CNT_WIDTH  saturating count of discarded writes

## Operation
- Arbiter: round-robin pointer rr. The first valid source at or after rr, in ascending modulo order, is granted. After each handshake, rr becomes granted index + 1 (mod N_SRC). rr is unchanged when there is no handshake.
- src_ready is combinational and one-hot or zero.
  - Stall mode: only the granted source sees ready, and only when full==0.
  - Drop mode: the granted source sees ready regardless of full.
- Handshake = src_valid[i] & src_ready[i]. At most one per cycle.
- Enqueue happens on a handshake when full==0 and the coordinates are in range.
- Discard happens on a handshake when full==1 (drop mode only) or when hpos ≥ RESOLUTION_H or vpos ≥ RESOLUTION_V. Each discard increments drop_cnt by 1, saturating at all-ones.
- full is sampled at the start of the cycle. A same-cycle pop does not free space for the push.
- Drain: pop = ~display_on & ~mem_busy & ~empty. FIFO head is show-ahead.
  - fb_we = pop.
  - fb_rgb = head rgb.
- Address mux:
  - fb_hpos/fb_vpos = raster hpos/vpos when display_on.
  - Otherwise they show the head entry, or zero when empty.
- level: +1 on enqueue, -1 on pop, unchanged on both or neither.
- Reset is asynchronous. It clears read/write pointers, level, rr and drop_cnt mid-operation; buffered entries are lost.
- Reset values of outputs:
  - src_ready = granted-if-valid (combinational).
  - fb_we = 0, empty = 1, full = 0, level = 0, drop_cnt = 0.
  - fb_hpos/fb_vpos follow the mux.

## Timing
- src_ready, fb_we and the fb_* outputs are combinational from current inputs and registered state; there are no output registers.
- Enqueue in cycle t: the entry is visible at the head in t+1. Earliest fb_we is t+1 if blanking and FIFO otherwise empty.
- Drain throughput is 1 write/cycle during blanking. Accept throughput is 1 write/cycle total across all sources.
- On a display_on rise, fb_we drops the same cycle. No write ever coincides with display_on=1 or mem_busy=1.
- Entries leave in enqueue order. Across sources, order equals grant order.

## Structure
- Package fb_pkg holds:
  - the FULL_STALL=0 / FULL_DROP=1 encodings;
  - the default RESOLUTION_H/V and coordinate widths shared with the VGA timing and framebuffer blocks;
  - a packed entry layout {hpos, vpos, rgb} with width constant FB_ENTRY_W.
- Sub-module fb_rr_arbiter (parameter N) takes valid, advance and the rr pointer, and returns a one-hot grant. The FIFO storage and pointers stay inline.

## Test plan
- Single source, stall mode, DEPTH=4, display_on=1, 6 valid writes → 4 accepted; src_ready low from cycle 4; full=1, level=4; fb_we=0 throughout.
- Drop full: FULL_POLICY=1, DEPTH=4, 6 writes during display → 4 enqueued, drop_cnt=2. Then display_on=0 → 4 consecutive fb_we pulses in enqueue order, then empty=1.
- Round-robin: N_SRC=3, all sources continuously valid, FIFO never full → grants 0,1,2,0,1,2; after rr=2 with only source 1 valid → grant 1.
- Clip: write (640,10) and (5,480) → both accepted (src_ready=1), not enqueued, drop_cnt=2, level=0.
- Blanking gate: 3 entries buffered, display_on=0, mem_busy=1 for 5 cycles then 0 → fb_we only after mem_busy falls. display_on rises after 2 writes → fb_we=0, fb_hpos=raster hpos, level=1.
- Async reset: reset_n low with level=3, drop_cnt=7 → level=0, empty=1, drop_cnt=0 immediately, without waiting for a clk edge; the first grant after release goes to source 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: full-policy encodings, default raster geometry
// and the packed {hpos, vpos, rgb} write-entry layout.
package fb_pkg;

    localparam int unsigned FULL_STALL = 0;
    localparam int unsigned FULL_DROP  = 1;

    localparam int unsigned FB_RES_H      = 640;
    localparam int unsigned FB_RES_V      = 480;
    localparam int unsigned FB_HPOS_WIDTH = 10;
    localparam int unsigned FB_VPOS_WIDTH = 10;
    localparam int unsigned FB_RGB_WIDTH  = 3;

    localparam int unsigned FB_ENTRY_W = FB_HPOS_WIDTH + FB_VPOS_WIDTH + FB_RGB_WIDTH;

    typedef struct packed {
        logic [FB_HPOS_WIDTH-1:0] hpos;
        logic [FB_VPOS_WIDTH-1:0] vpos;
        logic [FB_RGB_WIDTH-1:0]  rgb;
    } fb_entry_t;

endpackage

// File: rtl/fb_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after the rr pointer;
// the pointer moves past the granted index only when the grant is taken (advance).
module fb_rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] valid,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int unsigned RrW = (N > 1) ? $clog2(N) : 1;

    logic [RrW-1:0] rr_q, rr_d;
    logic [RrW-1:0] gidx;
    logic           found;
    int unsigned    idx;

    always_comb begin
        grant = '0;
        gidx  = rr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(rr_q) + k) % N;
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                gidx       = RrW'(idx);
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (advance) begin
            rr_d = (32'(gidx) == N - 1) ? '0 : gidx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// Multi-source framebuffer write scheduler: round-robin accept into a FIFO,
// drained to the framebuffer write port only while blanking and not clearing.
module fb_write_scheduler
    import fb_pkg::*;
#(
    parameter int unsigned N_SRC        = 2,
    parameter int unsigned HPOS_WIDTH   = FB_HPOS_WIDTH,
    parameter int unsigned VPOS_WIDTH   = FB_VPOS_WIDTH,
    parameter int unsigned RGB_WIDTH    = FB_RGB_WIDTH,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned RESOLUTION_H = FB_RES_H,
    parameter int unsigned RESOLUTION_V = FB_RES_V,
    parameter int unsigned FULL_POLICY  = FULL_STALL,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_SRC-1:0]              src_valid,
    output logic [N_SRC-1:0]              src_ready,
    input  logic [N_SRC*HPOS_WIDTH-1:0]   src_hpos,
    input  logic [N_SRC*VPOS_WIDTH-1:0]   src_vpos,
    input  logic [N_SRC*RGB_WIDTH-1:0]    src_rgb,
    input  logic                          display_on,
    input  logic                          mem_busy,
    input  logic [HPOS_WIDTH-1:0]         hpos,
    input  logic [VPOS_WIDTH-1:0]         vpos,
    output logic [HPOS_WIDTH-1:0]         fb_hpos,
    output logic [VPOS_WIDTH-1:0]         fb_vpos,
    output logic [RGB_WIDTH-1:0]          fb_rgb,
    output logic                          fb_we,
    output logic [$clog2(DEPTH+1)-1:0]    level,
    output logic                          full,
    output logic                          empty,
    output logic [CNT_WIDTH-1:0]          drop_cnt
);

    localparam int unsigned EntryW = HPOS_WIDTH + VPOS_WIDTH + RGB_WIDTH;
    localparam int unsigned AddrW  = $clog2(DEPTH);
    localparam int unsigned LvlW   = $clog2(DEPTH + 1);

    logic [N_SRC-1:0]      grant;
    logic                  accept_ok, handshake, in_range, push, pop, discard;
    logic [HPOS_WIDTH-1:0] sel_hpos;
    logic [VPOS_WIDTH-1:0] sel_vpos;
    logic [RGB_WIDTH-1:0]  sel_rgb;

    logic [EntryW-1:0]     mem [DEPTH];
    logic [EntryW-1:0]     head;
    logic [AddrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]       level_q, level_d;
    logic [CNT_WIDTH-1:0]  drop_q, drop_d;

    fb_rr_arbiter #(
        .N(N_SRC)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .valid   (src_valid),
        .advance (handshake),
        .grant   (grant)
    );

    // Drop mode keeps accepting when full so producers never stall; the write is counted.
    assign accept_ok = (FULL_POLICY == FULL_DROP) || !full;
    assign src_ready = accept_ok ? grant : '0;
    assign handshake = |(src_valid & src_ready);

    always_comb begin
        sel_hpos = '0;
        sel_vpos = '0;
        sel_rgb  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
                sel_hpos = src_hpos[i*HPOS_WIDTH +: HPOS_WIDTH];
                sel_vpos = src_vpos[i*VPOS_WIDTH +: VPOS_WIDTH];
                sel_rgb  = src_rgb[i*RGB_WIDTH +: RGB_WIDTH];
            end
        end
    end

    assign in_range = (32'(sel_hpos) < RESOLUTION_H) && (32'(sel_vpos) < RESOLUTION_V);
    assign push     = handshake && !full && in_range;
    assign discard  = handshake && (full || !in_range);
    assign pop      = !display_on && !mem_busy && !empty;

    assign full  = (level_q == LvlW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign drop_cnt = drop_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        drop_d = (discard && (drop_q != '1)) ? drop_q + 1'b1 : drop_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {sel_hpos, sel_vpos, sel_rgb};
        end
    end

    assign head   = mem[rd_ptr_q];
    assign fb_we  = pop;
    assign fb_rgb = head[RGB_WIDTH-1:0];

    // Raster owns the address bus during the visible area.
    always_comb begin
        if (display_on) begin
            fb_hpos = hpos;
            fb_vpos = vpos;
        end else if (empty) begin
            fb_hpos = '0;
            fb_vpos = '0;
        end else begin
            fb_hpos = head[EntryW-1 -: HPOS_WIDTH];
            fb_vpos = head[RGB_WIDTH +: VPOS_WIDTH];
        end
    end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Randomized bench for fb_write_scheduler: stall and drop instances share stimulus;
// a queue-based reference model predicts handshakes and a monitor checks drained data.
module tb_fb_write_scheduler;

    localparam int unsigned NS = 3;
    localparam int unsigned HW = 10;
    localparam int unsigned VW = 10;
    localparam int unsigned RW = 3;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned RH = 640;
    localparam int unsigned RV = 480;
    localparam int unsigned LW = $clog2(D + 1);
    localparam int unsigned EW = HW + VW + RW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [NS-1:0]    src_valid;
    logic [NS*HW-1:0] src_hpos;
    logic [NS*VW-1:0] src_vpos;
    logic [NS*RW-1:0] src_rgb;
    logic             display_on, mem_busy;
    logic [HW-1:0]    hpos;
    logic [VW-1:0]    vpos;

    logic [NS-1:0] rdy [2];
    logic [HW-1:0] fbh [2];
    logic [VW-1:0] fbv [2];
    logic [RW-1:0] fbr [2];
    logic          we  [2];
    logic [LW-1:0] lvl [2];
    logic          fl  [2];
    logic          em  [2];
    logic [CW-1:0] dc  [2];

    always #5 clk = ~clk;

    // Instance 0 stalls when full, instance 1 drops.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        fb_write_scheduler #(
            .N_SRC        (NS),
            .HPOS_WIDTH   (HW),
            .VPOS_WIDTH   (VW),
            .RGB_WIDTH    (RW),
            .DEPTH        (D),
            .RESOLUTION_H (RH),
            .RESOLUTION_V (RV),
            .FULL_POLICY  (g),
            .CNT_WIDTH    (CW)
        ) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .src_valid  (src_valid),
            .src_ready  (rdy[g]),
            .src_hpos   (src_hpos),
            .src_vpos   (src_vpos),
            .src_rgb    (src_rgb),
            .display_on (display_on),
            .mem_busy   (mem_busy),
            .hpos       (hpos),
            .vpos       (vpos),
            .fb_hpos    (fbh[g]),
            .fb_vpos    (fbv[g]),
            .fb_rgb     (fbr[g]),
            .fb_we      (we[g]),
            .level      (lvl[g]),
            .full       (fl[g]),
            .empty      (em[g]),
            .drop_cnt   (dc[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    int rr_m   [2];
    int cnt_m  [2];
    int dcnt_m [2];
    logic [EW-1:0] sbq0 [$];
    logic [EW-1:0] sbq1 [$];

    logic [HW-1:0] dir_h;
    logic [VW-1:0] dir_v;

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] sb_head(input int k);
        if (k == 0) return sbq0[0];
        return sbq1[0];
    endfunction

    // Reference model for one instance over the current cycle; then advances its state.
    task automatic model_cycle(input int k);
        int            g;
        int            idx;
        logic [NS-1:0] er;
        logic          hs, inr, push, disc, pop, fullm;
        logic [EW-1:0] e;
        logic [EW-1:0] hd;
        fullm = (cnt_m[k] == D);
        g = -1;
        for (int j = 0; j < NS; j++) begin
            idx = (rr_m[k] + j) % NS;
            if (g < 0 && src_valid[idx]) g = idx;
        end
        er = '0;
        if (g >= 0 && (k == 1 || !fullm)) er[g] = 1'b1;
        hs = (er != '0);
        e = '0;
        if (g >= 0) e = {src_hpos[g*HW +: HW], src_vpos[g*VW +: VW], src_rgb[g*RW +: RW]};
        inr  = (int'(e[EW-1 -: HW]) < RH) && (int'(e[RW +: VW]) < RV);
        push = hs && !fullm && inr;
        disc = hs && (fullm || !inr);
        pop  = !display_on && !mem_busy && cnt_m[k] > 0;

        check("src_ready", k, 32'(rdy[k]), 32'(er));
        check("fb_we", k, 32'(we[k]), 32'(pop));
        check("level", k, 32'(lvl[k]), 32'(cnt_m[k]));
        check("full", k, 32'(fl[k]), 32'(fullm));
        check("empty", k, 32'(em[k]), 32'(cnt_m[k] == 0));
        check("drop_cnt", k, 32'(dc[k]), 32'(dcnt_m[k]));
        if (display_on) begin
            check("fb_addr_raster", k, {fbh[k], fbv[k]}, {hpos, vpos});
        end else if (cnt_m[k] == 0) begin
            check("fb_addr_empty", k, {fbh[k], fbv[k]}, 32'd0);
        end else begin
            hd = sb_head(k);
            check("fb_addr_head", k, {fbh[k], fbv[k]}, 32'(hd[EW-1:RW]));
            check("fb_rgb_head", k, 32'(fbr[k]), 32'(hd[RW-1:0]));
        end

        if (hs) rr_m[k] = (g + 1) % NS;
        if (push) begin
            if (k == 0) sbq0.push_back(e);
            else sbq1.push_back(e);
        end
        cnt_m[k] = cnt_m[k] + int'(push) - int'(pop);
        if (disc && dcnt_m[k] < (1 << CW) - 1) dcnt_m[k]++;
    endtask

    // mode 0: in-range coords, 1: random with boundary/out-of-range, 2: dir_h/dir_v.
    task automatic step(input logic [NS-1:0] v, input logic disp, input logic busy,
                        input int mode);
        @(posedge clk);
        #1;
        src_valid  = v;
        display_on = disp;
        mem_busy   = busy;
        hpos = HW'($urandom_range(0, 1023));
        vpos = VW'($urandom_range(0, 1023));
        src_rgb = NS*RW'($urandom);
        for (int i = 0; i < NS; i++) begin
            logic [HW-1:0] h;
            logic [VW-1:0] vv;
            if (mode == 2) begin
                h  = dir_h;
                vv = dir_v;
            end else begin
                h  = HW'($urandom_range(0, RH - 1));
                vv = VW'($urandom_range(0, RV - 1));
                if (mode == 1) begin
                    case ($urandom_range(0, 9))
                        0: h = HW'(RH);
                        1: h = HW'(RH - 1);
                        2: vv = VW'(RV);
                        3: vv = VW'(RV - 1);
                        4: h = HW'($urandom_range(RH, 1023));
                        5: vv = VW'($urandom_range(RV, 1023));
                        default: ;
                    endcase
                end
            end
            src_hpos[i*HW +: HW] = h;
            src_vpos[i*VW +: VW] = vv;
        end
        #3;
        model_cycle(0);
        model_cycle(1);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            rr_m[k]   = 0;
            cnt_m[k]  = 0;
            dcnt_m[k] = 0;
        end
        sbq0.delete();
        sbq1.delete();
    endtask

    // Reset asserted away from any clock edge; state must clear immediately.
    task automatic async_reset();
        @(posedge clk);
        #5;
        src_valid  = '0;
        display_on = 1'b1;
        reset_n    = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_level", k, 32'(lvl[k]), 32'd0);
            check("rst_empty", k, 32'(em[k]), 32'd1);
            check("rst_full", k, 32'(fl[k]), 32'd0);
            check("rst_drop", k, 32'(dc[k]), 32'd0);
            check("rst_we", k, 32'(we[k]), 32'd0);
        end
        clear_model();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    // Drain monitor: every fb_we must carry the oldest outstanding accepted entry.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #6;
            for (int k = 0; k < 2; k++) begin
                if (we[k] === 1'b1) begin
                    n_checks++;
                    if (display_on !== 1'b0 || mem_busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL we_gate dut%0d t=%0t: got fb_we=1 expected 0", k, $time);
                    end
                    n_checks++;
                    if ((k == 0 ? sbq0.size() : sbq1.size()) == 0) begin
                        n_fail++;
                        $display("FAIL drain_extra dut%0d t=%0t: got write expected none",
                                 k, $time);
                    end else begin
                        n_checks--;
                        e = (k == 0) ? sbq0.pop_front() : sbq1.pop_front();
                        check("drain_data", k, {fbh[k], fbv[k], fbr[k]}, 32'(e));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t: got timeout expected finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic d;
        logic b;
        src_valid  = '0;
        src_hpos   = '0;
        src_vpos   = '0;
        src_rgb    = '0;
        display_on = 1'b1;
        mem_busy   = 1'b0;
        hpos       = '0;
        vpos       = '0;
        dir_h      = '0;
        dir_v      = '0;
        clear_model();
        #3;
        for (int k = 0; k < 2; k++) begin
            check("init_level", k, 32'(lvl[k]), 32'd0);
            check("init_empty", k, 32'(em[k]), 32'd1);
            check("init_full", k, 32'(fl[k]), 32'd0);
            check("init_drop", k, 32'(dc[k]), 32'd0);
            check("init_we", k, 32'(we[k]), 32'd0);
        end
        #10;
        reset_n = 1'b1;

        // Single source into a full FIFO during display.
        for (int i = 0; i < 6; i++) step(3'b001, 1'b1, 1'b0, 0);
        // Blanking but memory clear running, then drain, interrupted by display.
        for (int i = 0; i < 5; i++) step(3'b000, 1'b0, 1'b1, 0);
        for (int i = 0; i < 2; i++) step(3'b000, 1'b0, 1'b0, 0);
        for (int i = 0; i < 2; i++) step(3'b000, 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) step(3'b000, 1'b0, 1'b0, 0);

        // Round-robin with all sources valid and the FIFO draining.
        async_reset();
        for (int i = 0; i < 6; i++) step(3'b111, 1'b0, 1'b0, 0);
        for (int i = 0; i < 2; i++) step(3'b111, 1'b0, 1'b0, 0);
        step(3'b010, 1'b0, 1'b0, 0);
        step(3'b000, 1'b0, 1'b0, 0);

        // Clipped coordinates: accepted but discarded.
        dir_h = HW'(RH);
        dir_v = VW'(10);
        step(3'b001, 1'b1, 1'b0, 2);
        dir_h = HW'(5);
        dir_v = VW'(RV);
        step(3'b001, 1'b1, 1'b0, 2);
        dir_h = HW'(RH - 1);
        dir_v = VW'(RV - 1);
        step(3'b100, 1'b1, 1'b0, 2);
        for (int i = 0; i < 3; i++) step(3'b000, 1'b0, 1'b0, 0);

        // Random traffic with raster runs, clears and boundary coordinates.
        d = 1'b1;
        b = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) d = ~d;
            b = ($urandom_range(0, 3) == 0);
            step(NS'($urandom), d, b, 1);
        end

        // Build up state, reset mid-operation, first grant must go to source 0.
        for (int i = 0; i < 8; i++) step(3'b111, 1'b1, 1'b0, 1);
        async_reset();
        step(3'b111, 1'b1, 1'b0, 0);
        step(3'b110, 1'b1, 1'b0, 0);
        for (int i = 0; i < 8; i++) step(3'b000, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
